// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader: assembles a serial element stream into packed
// operand words A and B for the 2x2 matrix unit, presented through a
// registered valid/ready handshake.
// Optional checksum element per frame: define MATRIX_LOADER_CHECKSUM_EN.
module matrix_operand_loader #(
   parameter int unsigned ELEM_W = 8,
   parameter int unsigned ELEMS  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ELEM_W-1:0]        in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [ELEM_W*ELEMS-1:0]  a_out,
   output logic [ELEM_W*ELEMS-1:0]  b_out,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     busy,
   output logic                     err
);

   localparam int unsigned MAT_W = ELEM_W * ELEMS;
   localparam int unsigned IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ELEMS - 1);

   typedef enum logic [1:0] {
      LOAD_A  = 2'd0,
      LOAD_B  = 2'd1,
      CHECK   = 2'd2,
      PRESENT = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_idx;
   logic [IDX_W-1:0]   w_idx_nxt;
   logic [MAT_W-1:0]   r_stage_a;
   logic [MAT_W-1:0]   w_stage_a_nxt;
   logic [MAT_W-1:0]   r_stage_b;
   logic [MAT_W-1:0]   w_stage_b_nxt;
   logic [MAT_W-1:0]   r_a_out;
   logic [MAT_W-1:0]   r_b_out;
   logic               w_load_out;
   logic               r_in_ready;
   logic               r_out_valid;
   logic               r_busy;
   logic               r_err;
   logic               w_err_nxt;
   logic               w_accept;
   logic [ELEM_W-1:0]  r_csum;
   logic [ELEM_W-1:0]  w_csum_nxt;

   assign w_accept  = in_valid && r_in_ready;
   assign in_ready  = r_in_ready;
   assign a_out     = r_a_out;
   assign b_out     = r_b_out;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign err       = r_err;

   // Next-state, staging-slice writes and checksum accumulation
   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_stage_a_nxt = r_stage_a;
      w_stage_b_nxt = r_stage_b;
      w_load_out    = 1'b0;
      w_err_nxt     = 1'b0;
      w_csum_nxt    = r_csum;

      case (r_state)
         LOAD_A: begin
            if (w_accept) begin
               // First element of a matrix goes to the MSB slice
               for (int unsigned k = 0; k < ELEMS; k++) begin
                  if (r_idx == IDX_W'(k)) begin
                     w_stage_a_nxt[(ELEMS-1-k)*ELEM_W +: ELEM_W] = in_data;
                  end
               end
               w_csum_nxt = r_csum ^ in_data;
               if (r_idx == IDX_LAST) begin
                  w_idx_nxt   = '0;
                  w_state_nxt = LOAD_B;
               end else begin
                  w_idx_nxt = r_idx + IDX_W'(1);
               end
            end
         end

         LOAD_B: begin
            if (w_accept) begin
               for (int unsigned k = 0; k < ELEMS; k++) begin
                  if (r_idx == IDX_W'(k)) begin
                     w_stage_b_nxt[(ELEMS-1-k)*ELEM_W +: ELEM_W] = in_data;
                  end
               end
               w_csum_nxt = r_csum ^ in_data;
               if (r_idx == IDX_LAST) begin
                  w_idx_nxt = '0;
`ifdef MATRIX_LOADER_CHECKSUM_EN
                  w_state_nxt = CHECK;
`else
                  w_state_nxt = PRESENT;
                  w_load_out  = 1'b1;
`endif
               end else begin
                  w_idx_nxt = r_idx + IDX_W'(1);
               end
            end
         end

`ifdef MATRIX_LOADER_CHECKSUM_EN
         CHECK: begin
            if (w_accept) begin
               w_csum_nxt = '0;
               if (in_data == r_csum) begin
                  w_state_nxt = PRESENT;
                  w_load_out  = 1'b1;
               end else begin
                  // Bad checksum: drop the frame, outputs untouched
                  w_state_nxt = LOAD_A;
                  w_err_nxt   = 1'b1;
               end
            end
         end
`endif

         PRESENT: begin
            if (r_out_valid && out_ready) begin
               w_state_nxt = LOAD_A;
            end
         end

         default: begin
            w_state_nxt = LOAD_A;
            w_idx_nxt   = '0;
         end
      endcase
   end

   // State, staging and registered outputs; synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= LOAD_A;
         r_idx       <= '0;
         r_stage_a   <= '0;
         r_stage_b   <= '0;
         r_a_out     <= '0;
         r_b_out     <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
         r_csum      <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_stage_a   <= w_stage_a_nxt;
         r_stage_b   <= w_stage_b_nxt;
         if (w_load_out) begin
            r_a_out <= w_stage_a_nxt;
            r_b_out <= w_stage_b_nxt;
         end
         r_in_ready  <= (w_state_nxt != PRESENT);
         r_out_valid <= (w_state_nxt == PRESENT);
         r_busy      <= ((w_state_nxt == LOAD_A) && (w_idx_nxt != '0)) ||
                        (w_state_nxt == LOAD_B) || (w_state_nxt == CHECK);
         r_err       <= w_err_nxt;
         r_csum      <= w_csum_nxt;
      end
   end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// tb_matrix_operand_loader: directed stimulus with a scoreboard queue of
// expected operand pairs, drained by an independent output monitor.
module tb_matrix_operand_loader;

   localparam int unsigned ELEM_W = 8;
   localparam int unsigned ELEMS  = 4;
   localparam int unsigned MAT_W  = ELEM_W * ELEMS;

   typedef struct packed {
      logic [MAT_W-1:0] a;
      logic [MAT_W-1:0] b;
   } pair_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [ELEM_W-1:0] in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [MAT_W-1:0]  a_out;
   logic [MAT_W-1:0]  b_out;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic              busy;
   logic              err;

   int    checks = 0;
   int    errors = 0;
   pair_t exp_q[$];
   logic  mon_seen = 1'b0;

   matrix_operand_loader #(.ELEM_W(ELEM_W), .ELEMS(ELEMS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_out     (a_out),
      .b_out     (b_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [MAT_W-1:0] act,
                        input logic [MAT_W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
      pair_t p;
      p.a = a;
      p.b = b;
      exp_q.push_back(p);
   endtask

   // Offer one element, wait (bounded) for acceptance, then idle gap cycles
   task automatic send(input logic [ELEM_W-1:0] d, input int gap);
      int n;
      n = 0;
      in_data  = d;
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 200);
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready got 0 expected 1 (data 0x%0h)", d);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'hEE;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Full frame of 2*ELEMS consecutive values starting at first
   task automatic send_frame(input logic [ELEM_W-1:0] first, input int gap);
      logic [ELEM_W-1:0] x;
      x = '0;
      for (int i = 0; i < 2 * ELEMS; i++) begin
         send(ELEM_W'(first + ELEM_W'(i)), (i == 2 * ELEMS - 1) ? 0 : gap);
         x = x ^ ELEM_W'(first + ELEM_W'(i));
         if (i == 0) check("busy_after_first", MAT_W'(busy), MAT_W'(1));
      end
`ifdef MATRIX_LOADER_CHECKSUM_EN
      send(x, 0);
`endif
      check("latency_out_valid", MAT_W'(out_valid), MAT_W'(1));
      check("present_in_ready", MAT_W'(in_ready), MAT_W'(0));
      check("present_busy", MAT_W'(busy), MAT_W'(0));
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("hs_out_valid_drop", MAT_W'(out_valid), MAT_W'(0));
      check("hs_in_ready_rise", MAT_W'(in_ready), MAT_W'(1));
      out_ready = 1'b0;
   endtask

   // Monitor: compare each new presentation against the scoreboard head
   always @(negedge clk) begin
      if (!out_valid) begin
         mon_seen <= 1'b0;
      end else if (!mon_seen) begin
         mon_seen <= 1'b1;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL mon_unexpected: got a=0x%0h b=0x%0h expected no output", a_out, b_out);
         end else begin
            pair_t p;
            p = exp_q.pop_front();
            if (a_out !== p.a || b_out !== p.b) begin
               errors++;
               $display("FAIL mon_pair: got a=0x%0h b=0x%0h expected a=0x%0h b=0x%0h",
                        a_out, b_out, p.a, p.b);
            end
         end
      end
   end

   initial begin
      int n;

      // Reset held with in_valid asserted
      rst      = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h55;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rst_a_out", a_out, '0);
      check("rst_b_out", b_out, '0);
      check("rst_out_valid", MAT_W'(out_valid), MAT_W'(0));
      check("rst_in_ready", MAT_W'(in_ready), MAT_W'(0));
      check("rst_busy", MAT_W'(busy), MAT_W'(0));
      check("rst_err", MAT_W'(err), MAT_W'(0));
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", MAT_W'(in_ready), MAT_W'(1));
      check("post_rst_busy", MAT_W'(busy), MAT_W'(0));

      // Basic frame, back-to-back elements, then hold off the consumer
      push_exp(32'h01020304, 32'h05060708);
      send_frame(8'h01, 0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("stall_in_ready", MAT_W'(in_ready), MAT_W'(0));
         check("stall_out_valid", MAT_W'(out_valid), MAT_W'(1));
         check("stall_a_out", a_out, 32'h01020304);
         check("stall_b_out", b_out, 32'h05060708);
      end
      @(posedge clk);
      #1;
      handshake();
      check("after_hs_a_hold", a_out, 32'h01020304);

      // Same frame with bubbles between elements
      push_exp(32'h01020304, 32'h05060708);
      send_frame(8'h01, 2);
      handshake();

      // Partial frame discarded by a one-cycle reset
      send(8'hAA, 0);
      send(8'hBB, 0);
      send(8'hCC, 0);
      check("partial_busy", MAT_W'(busy), MAT_W'(1));
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      check("midrst_busy", MAT_W'(busy), MAT_W'(0));
      check("midrst_in_ready", MAT_W'(in_ready), MAT_W'(0));
      check("midrst_a_out", a_out, '0);
      push_exp(32'h10111213, 32'h14151617);
      send_frame(8'h10, 0);
      handshake();

      // Back-to-back frames with the consumer always ready
      out_ready = 1'b1;
      push_exp(32'h01020304, 32'h05060708);
      send_frame(8'h01, 0);
      send(8'h09, 0);
      check("b2b_a_hold", a_out, 32'h01020304);
      check("b2b_b_hold", b_out, 32'h05060708);
      push_exp(32'h090A0B0C, 32'h0D0E0F10);
      for (int i = 1; i < 2 * int'(ELEMS); i++) send(8'(9 + i), 0);
`ifdef MATRIX_LOADER_CHECKSUM_EN
      send(8'h18, 0);
`endif
      check("b2b_out_valid", MAT_W'(out_valid), MAT_W'(1));
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("b2b_released", MAT_W'(out_valid), MAT_W'(0));

`ifdef MATRIX_LOADER_CHECKSUM_EN
      // Good checksum already exercised above; now a bad one
      for (int i = 0; i < 2 * int'(ELEMS); i++) send(8'(1 + i), 0);
      send(8'h00, 0);
      check("csum_err_pulse", MAT_W'(err), MAT_W'(1));
      check("csum_out_valid", MAT_W'(out_valid), MAT_W'(0));
      check("csum_a_keep", a_out, 32'h090A0B0C);
      check("csum_b_keep", b_out, 32'h0D0E0F10);
      check("csum_busy", MAT_W'(busy), MAT_W'(0));
      @(posedge clk);
      #1;
      check("csum_err_clear", MAT_W'(err), MAT_W'(0));
      check("csum_out_valid2", MAT_W'(out_valid), MAT_W'(0));
      push_exp(32'h01020304, 32'h05060708);
      send_frame(8'h01, 0);
      handshake();
`else
      check("err_tied_low", MAT_W'(err), MAT_W'(0));
`endif

      // Let the monitor drain any pending expectations
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      check("scoreboard_drained", MAT_W'(exp_q.size()), MAT_W'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/matrix_operand_loader.md
Name: matrix_operand_loader

Overview:
Upstream feeder for the 2x2 matrix unit. Accepts a serial stream of matrix elements over a valid/ready handshake and assembles two packed operand words, A and B. Presents A and B to the matrix unit as stable, registered words with an output valid/ready handshake. Holds both words steady for the whole time the downstream unit consumes them.

Parameters:
ELEM_W, 8, width of one matrix element in bits
ELEMS, 4, elements per matrix (2x2); packed operand width is ELEM_W*ELEMS

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-low reset
in_data  input  ELEM_W  element byte from the upstream source
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  loader can accept an element this cycle
a_out  output  ELEM_W*ELEMS  packed matrix A, drives matrix unit input a
b_out  output  ELEM_W*ELEMS  packed matrix B, drives matrix unit input b
out_valid  output  1  a_out/b_out hold a complete operand pair
out_ready  input  1  downstream has taken the pair
busy  output  1  at least one element of the current frame has been accepted, frame not yet presented
err  output  1  checksum mismatch pulse (only with the optional feature; otherwise constant 0)

Behaviour:
- Reset: clk edge with rst=0 sets state LOAD_A, element index 0, and staging registers to 0. Outputs: a_out=0, b_out=0, out_valid=0, busy=0, err=0. in_ready is 1 from the first cycle after reset is released.
- Reset mid-frame discards any partial frame. No element accepted before the reset is used.
- Accept event: in_valid && in_ready at a rising edge. in_data is ignored when no accept event occurs.
- Frame format: ELEMS elements of A, then ELEMS elements of B, row-major order (a00, a01, a10, a11).
- Packing: the first accepted element of each matrix lands in the MSB slice [ELEM_W*ELEMS-1 -: ELEM_W]. The last element lands in [ELEM_W-1:0].
- States:
  - LOAD_A: in_ready=1. Each accept writes the staging A slice at the current index and increments the index. When the index reaches ELEMS-1, the accept wraps the index to 0 and moves to LOAD_B.
  - LOAD_B: in_ready=1. Loads staging B the same way. The last accept goes to PRESENT, or to CHECK when the optional feature is enabled.
  - PRESENT: in_ready=0, out_valid=1. a_out/b_out were loaded from staging on the edge that entered PRESENT. When out_valid && out_ready, the state goes to LOAD_A and out_valid=0 on the next cycle.
- Latency: out_valid rises on the cycle after the edge that accepted the final B element. Best-case throughput is one pair every 2*ELEMS+1 cycles.
- No bypass: in PRESENT no element is accepted, even if out_ready=1 in the same cycle. The next accept is possible one cycle after the handshake.
- a_out/b_out are dedicated output registers. They change only on entry to PRESENT and keep their last value after the handshake. The matrix unit inputs never see a partially loaded matrix.
- busy=1 in LOAD_A with index>0, and in LOAD_B or CHECK. Otherwise busy=0.
- out_ready while out_valid=0 has no effect.

Optional Feature:
Macro MATRIX_LOADER_CHECKSUM_EN.
- Defined:
  - After the last B element, the state is CHECK with in_ready=1.
  - The next accepted element is compared with the XOR of all 2*ELEMS frame elements.
  - Match: go to PRESENT as above.
  - Mismatch: discard the frame. err=1 for exactly one cycle, the cycle after the check accept. Return to LOAD_A. a_out/b_out and out_valid are unchanged (out_valid stays 0).
- Undefined: no CHECK state, err tied to 0, frame is exactly 2*ELEMS elements.

Test Plan:
1. Reset: hold rst=0 for 5 clks with in_valid=1 -> a_out=0, b_out=0, out_valid=0, in_ready=0. After release, in_ready=1.
2. Basic frame: stream 1..8 with in_valid held high -> one cycle after the 8th accept, out_valid=1, a_out=0x01020304, b_out=0x05060708.
3. Backpressure and gaps:
   - Insert in_valid=0 bubbles between elements -> same packed result as scenario 2.
   - Hold out_ready=0 for 6 cycles -> in_ready=0 throughout, outputs stable.
   - Then out_ready=1 -> out_valid=0 next cycle and in_ready=1.
4. Mid-frame reset: accept 3 elements, pulse rst=0 for 1 clk, then stream 0x10..0x17 -> a_out=0x10111213, b_out=0x14151617.
5. Back-to-back frames: frame 1..8, handshake, frame 9..16 -> second result a_out=0x090A0B0C, b_out=0x0D0E0F10. Values from frame 1 hold until the second PRESENT.
6. With MATRIX_LOADER_CHECKSUM_EN:
   - Frame 1..8 plus check 0x08 -> PRESENT with the scenario 2 values.
   - Same frame with check 0x00 -> err pulse of 1 cycle, out_valid stays 0, outputs unchanged.
